// File: rtl/regfile_core.sv
// regfile_core: general registers R1..R7 with R0 as a DIN pass-through, two combinational read ports and one synchronous write port.
// Define REGFILE_BYPASS_EN to forward RIN to a read port that selects the register being written in the same cycle.
module regfile_core #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SEL_W-1:0] DSEL,
    input  logic [SEL_W-1:0] ASEL,
    input  logic [SEL_W-1:0] BSEL,
    input  logic [WIDTH-1:0] DIN,
    input  logic [WIDTH-1:0] RIN,
    output logic [WIDTH-1:0] ABUS,
    output logic [WIDTH-1:0] BBUS
);

    localparam int NREG = 2 ** SEL_W;

    // Index 0 has no storage; selecting it reads DIN instead.
    logic [WIDTH-1:0] regs [1:NREG-1];
    logic             write_en;

    assign write_en = RST && (DSEL != '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[DSEL] <= RIN;
        end
    end

    always_comb begin
        ABUS = DIN;
        BBUS = DIN;
        for (int i = 1; i < NREG; i++) begin
            if (ASEL == SEL_W'(i)) ABUS = regs[i];
            if (BSEL == SEL_W'(i)) BBUS = regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by the same condition that commits the write.
        if (write_en && (ASEL == DSEL)) ABUS = RIN;
        if (write_en && (BSEL == DSEL)) BBUS = RIN;
`endif
    end

endmodule

// File: tb/tb_regfile_core.sv
// tb_regfile_core: randomized and directed stimulus for regfile_core with a queue-based scoreboard.
// A reference model predicts bus values before and after each clock edge; a monitor process compares them.
module tb_regfile_core;

    logic        CLK;
    logic        RST;
    logic [2:0]  DSEL;
    logic [2:0]  ASEL;
    logic [2:0]  BSEL;
    logic [15:0] DIN;
    logic [15:0] RIN;
    logic [15:0] ABUS;
    logic [15:0] BBUS;

    typedef struct {
        string       tag;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } expect_t;

    expect_t     sb_q [$];
    event        sample_ev;
    int          vectors_applied = 0;
    int          miscompares = 0;

    logic [15:0] model_regs [1:7];
    bit          model_valid = 0;

    regfile_core #(.WIDTH(16), .SEL_W(3)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .DSEL (DSEL),
        .ASEL (ASEL),
        .BSEL (BSEL),
        .DIN  (DIN),
        .RIN  (RIN),
        .ABUS (ABUS),
        .BBUS (BBUS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] model_read(input logic [2:0] sel, input bit pre_edge);
        logic [15:0] v;
        v = (sel == 3'd0) ? DIN : model_regs[sel];
`ifdef REGFILE_BYPASS_EN
        if (pre_edge && RST && DSEL != 3'd0 && sel == DSEL) v = RIN;
`else
        if (pre_edge) v = v;
`endif
        return v;
    endfunction

    task automatic checkOutput(input expect_t e);
        vectors_applied++;
        if (ABUS !== e.exp_a || BBUS !== e.exp_b) begin
            miscompares++;
            $display("[TB] FAIL %s: ABUS=%h BBUS=%h, required ABUS=%h BBUS=%h",
                     e.tag, ABUS, BBUS, e.exp_a, e.exp_b);
        end
    endtask

    // Monitor: drains every expectation published by the driver at the moment it is published.
    initial begin
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                checkOutput(sb_q.pop_front());
            end
        end
    end

    task automatic push_expect(input string tag, input bit pre_edge);
        expect_t e;
        e.tag   = tag;
        e.exp_a = model_read(ASEL, pre_edge);
        e.exp_b = model_read(BSEL, pre_edge);
        sb_q.push_back(e);
        -> sample_ev;
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] dsel, input logic [2:0] asel,
                                 input logic [2:0] bsel, input logic [15:0] din,
                                 input logic [15:0] rin, input string tag);
        @(negedge CLK);
        RST  = rst;
        DSEL = dsel;
        ASEL = asel;
        BSEL = bsel;
        DIN  = din;
        RIN  = rin;
        #1;
        if (model_valid) push_expect({tag, "_pre"}, 1'b1);
        @(posedge CLK);
        if (!rst) begin
            for (int i = 1; i < 8; i++) model_regs[i] = 16'h0000;
            model_valid = 1;
        end else if (dsel != 3'd0) begin
            model_regs[dsel] = rin;
        end
        #1;
        if (model_valid) push_expect({tag, "_post"}, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; DSEL = '0; ASEL = '0; BSEL = '0; DIN = '0; RIN = '0;

        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, "reset1");
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, "reset2");
        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 3'd0, 3'(k), 3'd0, 16'h0, 16'h0, "reset_a");
        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 3'd0, 3'd0, 3'(k), 16'h0, 16'h0, "reset_b");

        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 3'(k), 3'd0, 3'd0, 16'h0, 16'(k), "write_sweep");
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd0, 16'd15, 16'd10, "no_write");

        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 3'd0, 3'(k), 3'd0, 16'h0, 16'd10, "readback_a");
        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 3'd0, 3'd0, 3'(k), 16'h0, 16'd10, "readback_b");
        applyStimulus(1'b1, 3'd0, 3'd0, 3'd0, 16'd16, 16'h0, "din_pass");

        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b1, 3'(k), 3'(k), 3'(k), 16'h0, 16'(7 + k), "same_reg_w1");
            applyStimulus(1'b1, 3'(k), 3'(k), 3'(k), 16'h0, 16'(14 + k), "same_reg_w2");
        end

        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, "reset3");
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, "reset4");
        for (int k = 1; k < 8; k++) applyStimulus(1'b1, 3'd0, 3'(k), 3'(k), 16'h0, 16'h0, "reset_sweep");

        applyStimulus(1'b1, 3'd3, 3'd0, 3'd0, 16'h0, 16'h5555, "prep_r3");
        applyStimulus(1'b0, 3'd3, 3'd3, 3'd0, 16'h0, 16'hABCD, "reset_vs_write");
        applyStimulus(1'b1, 3'd0, 3'd3, 3'd3, 16'h0, 16'h0, "r3_after_reset");
        applyStimulus(1'b1, 3'd5, 3'd5, 3'd0, 16'h0, 16'h1234, "bypass_r5");

        // Random traffic with occasional mid-sequence resets.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), "random");
        end

        #2;
        if (sb_q.size() != 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
